pkt_wrr_arbiter: RTL and testbench

PKT_WRR_ARBITER -- requirements
Module: pkt_wrr_arbiter

---
 rtl/pkt_arb_pkg.sv | 21 ++
 rtl/pkt_skid_buf.sv | 54 +++++
 rtl/pkt_wrr_arbiter.sv | 152 +++++++++++++++
 tb/tb_pkt_wrr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the packet weighted round-robin arbiter.
// Holds the arbiter FSM encoding and the index-width helper.
package pkt_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Width of a channel index; never below one bit so single-channel builds stay legal.
    function automatic int idx_w(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry skid buffer: registered output, upstream ready taken only from local state.
// Accepted beat is visible on the output the cycle after it is pushed.
module pkt_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_main_v;
    logic         r_skid_v;
    logic [W-1:0] r_main_d;
    logic [W-1:0] r_skid_d;
    logic         w_push;
    logic         w_pop;

    assign o_ready = ~r_skid_v;
    assign o_valid = r_main_v;
    assign o_data  = r_main_d;
    assign w_push  = i_valid & ~r_skid_v;
    assign w_pop   = r_main_v & i_ready;

    // Main/skid register update; the skid entry only fills when main is held by a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= {W{1'b0}};
            r_skid_d <= {W{1'b0}};
        end else if (r_skid_v) begin
            if (w_pop) begin
                r_main_d <= r_skid_d;
                r_skid_v <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_main_v || w_pop) begin
                r_main_d <= i_data;
                r_main_v <= 1'b1;
            end else begin
                r_skid_d <= i_data;
                r_skid_v <= 1'b1;
            end
        end else if (w_pop) begin
            r_main_v <= 1'b0;
        end
    end

endmodule

// File: rtl/pkt_wrr_arbiter.sv
// Packet-level weighted round-robin arbiter merging REQ_NUM beat streams into one.
// A grantee holds the output for a whole packet; weight gives packets per turn.
module pkt_wrr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int REQ_NUM  = 8,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_NUM-1:0]           valid_in,
    input  logic [REQ_NUM*DATA_W-1:0]    data_in,
    input  logic [REQ_NUM-1:0]           last_in,
    input  logic [REQ_NUM*WEIGHT_W-1:0]  weight_in,
    output logic [REQ_NUM-1:0]           ready_in,
    output logic                         valid_out,
    output logic                         last_out,
    output logic [DATA_W-1:0]            data_out,
    output logic [idx_w(REQ_NUM)-1:0]    grant_id_out,
    input  logic                         ready_out
);

    localparam int ID_W = idx_w(REQ_NUM);
    localparam int PL_W = DATA_W + 1 + ID_W;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(REQ_NUM - 1);
    localparam logic [ID_W:0]   NUM_EXT  = (ID_W + 1)'(REQ_NUM);

    arb_state_e            r_state;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_grant;
    logic [WEIGHT_W-1:0]   r_credit;

    logic [REQ_NUM-1:0]    w_elig;
    logic [2*REQ_NUM-1:0]  w_dbl;
    logic [ID_W-1:0]       w_start;
    logic [ID_W:0]         w_start_ext;
    logic [REQ_NUM-1:0]    w_rot;
    logic [ID_W-1:0]       w_off;
    logic [ID_W:0]         w_sum;
    logic [ID_W-1:0]       w_rr_sel;
    logic                  w_any;
    logic                  w_keep;
    logic [ID_W-1:0]       w_sel;
    logic [WEIGHT_W-1:0]   w_new_weight;
    logic                  w_skid_in_valid;
    logic                  w_skid_in_ready;
    logic [PL_W-1:0]       w_skid_in_data;
    logic [PL_W-1:0]       w_skid_out_data;
    logic                  w_in_fire;
    logic                  w_in_last;

    function automatic logic [ID_W-1:0] lowest_set(input logic [REQ_NUM-1:0] v);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Eligibility: a channel competes only with a pending beat and a non-zero weight.
    always_comb begin
        w_elig = {REQ_NUM{1'b0}};
        for (int i = 0; i < REQ_NUM; i++) begin
            w_elig[i] = valid_in[i] & (weight_in[i*WEIGHT_W +: WEIGHT_W] != {WEIGHT_W{1'b0}});
        end
    end

    // Rotate so the search origin (pointer+1) sits at bit 0, pick lowest, rotate the index back.
    always_comb begin
        w_start      = (r_ptr == LAST_IDX) ? {ID_W{1'b0}} : r_ptr + ID_W'(1);
        w_start_ext  = {1'b0, w_start};
        w_dbl        = {w_elig, w_elig};
        w_rot        = w_dbl[w_start_ext +: REQ_NUM];
        w_off        = lowest_set(w_rot);
        w_sum        = {1'b0, w_off} + w_start_ext;
        w_rr_sel     = ID_W'((w_sum >= NUM_EXT) ? (w_sum - NUM_EXT) : w_sum);
        w_any        = |w_elig;
        w_keep       = (r_credit != {WEIGHT_W{1'b0}}) & w_elig[r_grant];
        w_sel        = w_keep ? r_grant : w_rr_sel;
        w_new_weight = weight_in[w_rr_sel*WEIGHT_W +: WEIGHT_W];
    end

    // Grantee's input stream feeds the skid buffer only while locked.
    always_comb begin
        w_skid_in_valid = (r_state == LOCKED) & valid_in[r_grant];
        w_in_last       = last_in[r_grant];
        w_in_fire       = w_skid_in_valid & w_skid_in_ready;
        w_skid_in_data  = {data_in[r_grant*DATA_W +: DATA_W], last_in[r_grant], r_grant};
        ready_in        = {REQ_NUM{1'b0}};
        for (int i = 0; i < REQ_NUM; i++) begin
            ready_in[i] = (r_state == LOCKED) & (r_grant == ID_W'(i)) & w_skid_in_ready;
        end
    end

    // Arbitration FSM: one IDLE cycle picks the grantee, LOCKED holds it until its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= LAST_IDX;
            r_grant  <= {ID_W{1'b0}};
            r_credit <= {WEIGHT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= LOCKED;
                        r_grant <= w_sel;
                        if (w_keep) begin
                            r_credit <= (r_credit == {WEIGHT_W{1'b0}}) ? {WEIGHT_W{1'b0}}
                                                                        : r_credit - WEIGHT_W'(1);
                        end else begin
                            r_ptr    <= w_rr_sel;
                            r_credit <= w_new_weight - WEIGHT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (w_in_fire && w_in_last) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    pkt_skid_buf #(
        .W (PL_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_skid_in_valid),
        .i_data  (w_skid_in_data),
        .o_ready (w_skid_in_ready),
        .o_valid (valid_out),
        .o_data  (w_skid_out_data),
        .i_ready (ready_out)
    );

    assign data_out     = w_skid_out_data[PL_W-1 -: DATA_W];
    assign last_out     = w_skid_out_data[ID_W];
    assign grant_id_out = w_skid_out_data[ID_W-1:0];

endmodule

// File: tb/tb_pkt_wrr_arbiter.sv
// Directed scoreboard bench for pkt_wrr_arbiter (8 channels, 8-bit data, 4-bit weights).
module tb_pkt_wrr_arbiter;

    logic        clk;
    logic        rst;
    logic [7:0]  valid_in;
    logic [63:0] data_in;
    logic [7:0]  last_in;
    logic [31:0] weight_in;
    logic [7:0]  ready_in;
    logic        valid_out;
    logic        last_out;
    logic [7:0]  data_out;
    logic [2:0]  grant_id_out;
    logic        ready_out;

    typedef struct packed {
        logic [2:0] ch;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic [8:0] src_q [8][$];
    beat_t      sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_start_cyc = -1;
    bit         exp_first = 1'b1;
    bit         chk_period = 1'b0;
    bit         chk_idle   = 1'b0;
    bit         rnd_ready  = 1'b0;
    bit         prev_stall = 1'b0;
    beat_t      prev_o;

    pkt_wrr_arbiter #(.REQ_NUM(8), .DATA_W(8), .WEIGHT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .last_in      (last_in),
        .weight_in    (weight_in),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .last_out     (last_out),
        .data_out     (data_out),
        .grant_id_out (grant_id_out),
        .ready_out    (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pkt_data(input int ch, input int id, input int b);
        return 8'(ch * 32 + id * 8 + b);
    endfunction

    task automatic src_pkt(input int ch, input int id);
        for (int b = 0; b < 8; b++) src_q[ch].push_back({(b == 7), pkt_data(ch, id, b)});
    endtask

    task automatic exp_pkt(input int ch, input int id);
        for (int b = 0; b < 8; b++) sb_q.push_back({3'(ch), (b == 7), pkt_data(ch, id, b)});
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            if (src_q[i].size() != 0) begin
                valid_in[i]          = 1'b1;
                last_in[i]           = src_q[i][0][8];
                data_in[i*8 +: 8]    = src_q[i][0][7:0];
            end else begin
                valid_in[i]          = 1'b0;
                last_in[i]           = 1'b0;
                data_in[i*8 +: 8]    = 8'h00;
            end
        end
        ready_out = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic tick();
        logic [7:0] fire_in;
        bit         fire_out;
        beat_t      o;
        beat_t      e;
        @(negedge clk);
        fire_in  = valid_in & ready_in;
        fire_out = valid_out & ready_out;
        o        = {grant_id_out, last_out, data_out};
        if (chk_idle) begin
            check("idle_ready_in", 32'(ready_in), 32'h0);
            check("idle_valid_out", 32'(valid_out), 32'h0);
        end
        if (prev_stall) begin
            check("stall_valid", 32'(valid_out), 32'h1);
            check("stall_stable", 32'(o), 32'(prev_o));
        end
        prev_stall = valid_out & ~ready_out;
        prev_o     = o;
        if (fire_out) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 32'(o), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("out_ch", 32'(o.ch), 32'(e.ch));
                check("out_data", 32'(o.data), 32'(e.data));
                check("out_last", 32'(o.last), 32'(e.last));
                if (exp_first) begin
                    if (chk_period && last_start_cyc >= 0) check("pkt_period", 32'(cyc - last_start_cyc), 32'd9);
                    last_start_cyc = cyc;
                end
                exp_first = e.last;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 8; i++) if (fire_in[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic run_until_empty(input int limit, input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(sb_q.size()), 32'h0);
    endtask

    task automatic reset_check();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) src_q[i].delete();
        sb_q.delete();
        prev_stall     = 1'b0;
        exp_first      = 1'b1;
        last_start_cyc = -1;
        drive();
        @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_last_out", 32'(last_out), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_grant_id", 32'(grant_id_out), 32'h0);
        check("rst_ready_in", 32'(ready_in), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        weight_in = {8{4'd1}};
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_check();

        // All channels, weight 1: grant order 0..7 then 0, 9 cycles per packet.
        for (int c = 0; c < 8; c++) src_pkt(c, 0);
        src_pkt(0, 1);
        for (int c = 0; c < 8; c++) exp_pkt(c, 0);
        exp_pkt(0, 1);
        chk_period = 1'b1;
        drive();
        run_until_empty(200, "rr8");
        chk_period = 1'b0;

        // ch0 weight 3, ch1 weight 1: 0,0,0,1,0,0,0,1.
        reset_check();
        weight_in[3:0] = 4'd3;
        weight_in[7:4] = 4'd1;
        for (int k = 0; k < 6; k++) src_pkt(0, k);
        src_pkt(1, 0);
        src_pkt(1, 1);
        exp_pkt(0, 0); exp_pkt(0, 1); exp_pkt(0, 2); exp_pkt(1, 0);
        exp_pkt(0, 3); exp_pkt(0, 4); exp_pkt(0, 5); exp_pkt(1, 1);
        drive();
        run_until_empty(200, "wrr31");

        // ch2 valid with weight 0: never accepted, nothing output.
        reset_check();
        weight_in       = {8{4'd1}};
        weight_in[11:8] = 4'd0;
        src_pkt(2, 0);
        drive();
        chk_idle = 1'b1;
        repeat (20) tick();
        chk_idle = 1'b0;
        check("w0_src_untouched", 32'(src_q[2].size()), 32'd8);

        // Random downstream backpressure across two packets.
        reset_check();
        weight_in = {8{4'd1}};
        src_pkt(3, 0);
        src_pkt(4, 0);
        exp_pkt(3, 0);
        exp_pkt(4, 0);
        rnd_ready = 1'b1;
        drive();
        run_until_empty(400, "bp");
        rnd_ready = 1'b0;

        // Advance pointer past 0, then reset mid-packet on ch5.
        src_pkt(6, 0);
        exp_pkt(6, 0);
        drive();
        run_until_empty(40, "pre5");
        src_pkt(5, 0);
        exp_pkt(5, 0);
        drive();
        n = 0;
        while (src_q[5].size() > 4 && n < 40) begin
            tick();
            n++;
        end
        check("ch5_four_beats", 32'(src_q[5].size()), 32'd4);
        reset_check();
        check("post_rst_sb_empty", 32'(sb_q.size()), 32'h0);
        src_pkt(2, 1);
        src_pkt(6, 1);
        exp_pkt(2, 1);
        exp_pkt(6, 1);
        drive();
        run_until_empty(60, "after_rst");

        // ch7 granted; ch0 and ch6 arrive during its packet: wrap to ch0 next.
        src_pkt(7, 0);
        exp_pkt(7, 0);
        drive();
        n = 0;
        while (src_q[7].size() == 8 && n < 20) begin
            tick();
            n++;
        end
        check("ch7_started", 32'(src_q[7].size()), 32'd7);
        src_pkt(0, 2);
        src_pkt(6, 2);
        exp_pkt(0, 2);
        exp_pkt(6, 2);
        drive();
        run_until_empty(80, "wrap");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
